// File: rtl/border_pkg.sv
// border_pkg: shared pixel type, FSM states and threshold compares for stream_border_detect
package border_pkg;
    localparam int PIX_BITS = 8;
    typedef logic [PIX_BITS-1:0] pix_t;
    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_e;
    function automatic logic is_fg(input logic [31:0] p, input logic [31:0] thr);
        return p > thr;
    endfunction
    function automatic logic is_bg(input logic [31:0] p, input logic [31:0] thr);
        return p < thr;
    endfunction
endpackage

// File: rtl/line_buffer.sv
// line_buffer: DEPTH-entry delay line, advancing one slot per enabled cycle
module line_buffer #(
    parameter int DEPTH = 9,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    always_ff @(posedge clk)
        if (en) mem <= {mem[DEPTH-2:0], d};
    assign q = mem[DEPTH-1];
endmodule

// File: rtl/stream_border_detect.sv
// stream_border_detect: streaming 3x3 border detector over valid/ready pixels
// Optional EDGE_COUNT_EN adds a per-frame count of non-zero output pixels.
module stream_border_detect
    import border_pkg::*;
#(
    parameter int          IMG_W  = 9,
    parameter int          IMG_H  = 9,
    parameter int          PIX_W  = 8,
    parameter int unsigned THRESH = 127
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_last
`ifdef EDGE_COUNT_EN
    ,
    output logic [$clog2(IMG_W*IMG_H+1)-1:0] edge_count,
    output logic                             count_valid
`endif
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int FW = $clog2(IMG_W + 2);
    localparam logic [PIX_W-1:0] TH = PIX_W'(THRESH);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    state_e state, state_nx;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [FW-1:0] fcnt;
    logic up, free, in_xfer, out_xfer, load_flush, border, bg_any;
    logic [PIX_W-1:0] lb0_q, lb1_q, t1, m1, b1, t2, m2, b2, result;
    logic [7:0][PIX_W-1:0] nb;

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (.clk(clk), .en(in_xfer), .d(in_pixel), .q(lb0_q));
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (.clk(clk), .en(in_xfer), .d(lb0_q), .q(lb1_q));

    assign free       = !out_valid || out_ready;
    assign in_ready   = up && (state == FILL || (state == RUN && free));
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = out_valid && out_ready;
    assign load_flush = state == FLUSH && fcnt != FW'(IMG_W + 1) && free;

    // Column 0 is the live column (in_pixel and both line-buffer taps); m1 is the centre.
    always_ff @(posedge clk)
        if (in_xfer) {t2, m2, b2, t1, m1, b1} <= {t1, m1, b1, lb1_q, lb0_q, in_pixel};

    assign nb = {t2, m2, b2, t1, b1, lb1_q, lb0_q, in_pixel};
    // Centre sits one column and one row behind the input, so it is on the border exactly when col<2 or row<2.
    assign border = col < CW'(2) || row < RW'(2);

    always_comb begin
        bg_any = 1'b0;
        for (int k = 0; k < 8; k++) bg_any = bg_any | is_bg(32'(nb[k]), 32'(TH));
        result = (!border && bg_any && is_fg(32'(m1), 32'(TH))) ? m1 : '0;
    end

    always_comb begin
        state_nx = state;
        if (state == FILL && in_xfer && row == RW'(1) && col == '0) state_nx = RUN;
        if (state == RUN && in_xfer && row == ROW_MAX && col == COL_MAX) state_nx = FLUSH;
        if (state == FLUSH && out_xfer && out_last) state_nx = FILL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            col       <= '0;
            row       <= '0;
            fcnt      <= '0;
            up        <= 1'b0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_last  <= 1'b0;
        end else begin
            up    <= 1'b1;
            state <= state_nx;
            if (in_xfer) begin
                col <= col == COL_MAX ? '0 : col + 1'b1;
                if (col == COL_MAX) row <= row == ROW_MAX ? '0 : row + 1'b1;
            end
            fcnt <= state == FLUSH ? fcnt + FW'(load_flush) : '0;
            if (state == RUN && in_xfer) begin
                out_valid <= 1'b1;
                out_pixel <= result;
                out_last  <= 1'b0;
            end else if (load_flush) begin
                out_valid <= 1'b1;
                out_pixel <= '0;
                out_last  <= fcnt == FW'(IMG_W);
            end else if (out_xfer) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

`ifdef EDGE_COUNT_EN
    localparam int EW = $clog2(IMG_W*IMG_H+1);
    // The final beat is always a border zero, so the register already holds the total on it.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) edge_count <= '0;
        else if (out_xfer) edge_count <= out_last ? '0 : edge_count + EW'(out_pixel != '0);
    assign count_valid = out_xfer && out_last;
`endif
endmodule

// File: tb/tb_stream_border_detect.sv
// tb_stream_border_detect: directed, table-driven checks of stream_border_detect on 9x9 frames
module tb_stream_border_detect;
    localparam int W = 9;
    localparam int H = 9;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [7:0] in_pixel = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [7:0] out_pixel;
    logic out_last;
`ifdef EDGE_COUNT_EN
    logic [$clog2(N+1)-1:0] edge_count;
    logic count_valid;
    int ec_at_last, cv_pulses;
`endif

    stream_border_detect dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel), .out_last(out_last)
`ifdef EDGE_COUNT_EN
        , .edge_count(edge_count), .count_valid(count_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int base, sx, sy, sv;
        int exp_cnt, exp_44, exp_33;
    } vec_t;

    vec_t vecs[8];
    int cur_img[N], exp_pix[N], got_pix[N], got_last[N];
    int n_out, n_last, n_tests, n_fail;

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic build(input int base, input int sx, input int sy, input int sv);
        for (int p = 0; p < N; p++) cur_img[p] = base;
        cur_img[sy*W+sx] = sv;
    endtask

    // Independent 2D reference: border zero, else centre kept if fg with any strict-bg neighbour.
    task automatic model();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                int c;
                bit bg;
                c = cur_img[y*W+x];
                bg = 0;
                if (x == 0 || y == 0 || x == W-1 || y == H-1) exp_pix[y*W+x] = 0;
                else begin
                    for (int dy = -1; dy <= 1; dy++)
                        for (int dx = -1; dx <= 1; dx++)
                            if ((dx != 0 || dy != 0) && cur_img[(y+dy)*W+x+dx] < 127) bg = 1;
                    exp_pix[y*W+x] = (c > 127 && bg) ? c : 0;
                end
            end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 0;
        out_ready = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_pixel", int'(out_pixel), 0);
        chk("rst_out_last", int'(out_last), 0);
`ifdef EDGE_COUNT_EN
        chk("rst_edge_count", int'(edge_count), 0);
        chk("rst_count_valid", int'(count_valid), 0);
`endif
        rst_n = 1;
    endtask

    task automatic run_frame(input bit bp, input int abort_at);
        int ni, cyc, held;
        bit stalled;
        ni = 0; cyc = 0; n_out = 0; n_last = 0; stalled = 0; held = 0;
`ifdef EDGE_COUNT_EN
        ec_at_last = -1; cv_pulses = 0;
`endif
        while (n_out < N && !(abort_at >= 0 && ni >= abort_at)) begin
            @(negedge clk);
            if (++cyc > 3000) begin
                n_tests++; n_fail++;
                $display("FAIL frame_timeout: got %0d outputs expected %0d", n_out, N);
                break;
            end
            in_valid = ni < N && (!bp || $urandom_range(0, 2) != 0);
            in_pixel = ni < N ? 8'(cur_img[ni]) : 8'd0;
            out_ready = !bp || $urandom_range(0, 1) == 1;
            #1;
            if (stalled) begin
                chk("stall_hold_pixel", int'(out_pixel), held);
                chk("stall_hold_valid", int'(out_valid), 1);
            end
            if (in_valid && in_ready) ni++;
            if (out_valid && out_ready) begin
                got_pix[n_out] = int'(out_pixel);
                got_last[n_out] = int'(out_last);
                if (out_last) n_last++;
                n_out++;
            end
`ifdef EDGE_COUNT_EN
            if (count_valid) begin
                cv_pulses++;
                ec_at_last = int'(edge_count);
            end
`endif
            stalled = out_valid && !out_ready;
            held = int'(out_pixel);
        end
        @(negedge clk);
        in_valid = 0;
        out_ready = 0;
    endtask

    task automatic check_frame(input string name);
        chk({name, "_count"}, n_out, N);
        chk({name, "_lasts"}, n_last, 1);
        for (int p = 0; p < n_out; p++) begin
            chk($sformatf("%s_pix%0d", name, p), got_pix[p], exp_pix[p]);
            chk($sformatf("%s_last%0d", name, p), got_last[p], int'(p == N-1));
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        vecs[0] = '{"all200",       200, 4, 4, 200, 0, 0,   0};
        vecs[1] = '{"hole10",       200, 4, 4, 10,  8, 0,   200};
        vecs[2] = '{"eq127",        200, 4, 4, 127, 0, 0,   0};
        vecs[3] = '{"spot200",      10,  4, 4, 200, 1, 200, 0};
        vecs[4] = '{"hole_1_1",     200, 1, 1, 10,  3, 0,   0};
        vecs[5] = '{"hole_corner",  200, 0, 0, 10,  1, 0,   0};
        vecs[6] = '{"sides126",     128, 4, 4, 126, 8, 0,   128};
        vecs[7] = '{"b128_eq127",   128, 4, 4, 127, 0, 0,   0};
        do_reset();
        for (int v = 0; v < 8; v++) begin
            int nz;
            build(vecs[v].base, vecs[v].sx, vecs[v].sy, vecs[v].sv);
            model();
            run_frame(0, -1);
            check_frame(vecs[v].name);
            nz = 0;
            for (int p = 0; p < n_out; p++) if (got_pix[p] != 0) nz++;
            chk({vecs[v].name, "_edges"}, nz, vecs[v].exp_cnt);
            chk({vecs[v].name, "_p44"}, got_pix[4*W+4], vecs[v].exp_44);
            chk({vecs[v].name, "_p33"}, got_pix[3*W+3], vecs[v].exp_33);
        end

        build(200, 4, 4, 10);
        model();
        run_frame(1, -1);
        check_frame("bp_hole10");

        build(200, 4, 4, 10);
        model();
        run_frame(0, -1);
        check_frame("b2b_a");
        build(10, 6, 2, 200);
        model();
        run_frame(0, -1);
        check_frame("b2b_b");
        build(200, 4, 4, 10);
        run_frame(0, 40);
        chk("abort_no_last", n_last, 0);
        do_reset();
        build(10, 6, 2, 200);
        model();
        run_frame(0, -1);
        check_frame("resent_b");

`ifdef EDGE_COUNT_EN
        build(200, 4, 4, 10);
        model();
        run_frame(0, -1);
        chk("ec_hole10_total", ec_at_last, 8);
        chk("ec_hole10_pulses", cv_pulses, 1);
        build(200, 4, 4, 200);
        model();
        run_frame(1, -1);
        chk("ec_all200_total", ec_at_last, 0);
        chk("ec_all200_pulses", cv_pulses, 1);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
